fast_ring_fetcher: RTL and testbench

- Sequencer that drives a single-port synchronous image SRAM (2D x/y addressed, 1-cycle read latency) to gather one FAST-9/12 sample set: the centre pixel plus the 16-pixel Bresenham ring of radius 3.
- Sits between the corner-scoring datapath (requester) and the image SRAM.
- Reads are serialised one per cycle, with out-of-image points zero-filled without touching the SRAM.
- Results are presented as one packed vector with a single-cycle done pulse.

---
 rtl/fast_ring_fetcher.sv | 151 +++++++++++++++
 tb/tb_fast_ring_fetcher.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_ring_fetcher.sv
// FAST-9/12 sample gatherer: centre pixel plus 16-pixel radius-3 ring,
// read serially from a 1-cycle-latency x/y addressed image SRAM.
module fast_ring_fetcher #(
  parameter int PIXEL_DEPTH = 8,
  parameter int X_MAX       = 5,
  parameter int Y_MAX       = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(X_MAX)-1:0]      cx,
  input  logic [$clog2(Y_MAX)-1:0]      cy,
  output logic                          busy,
  output logic                          done,
  output logic [PIXEL_DEPTH-1:0]        center_px,
  output logic [16*PIXEL_DEPTH-1:0]     ring_px,
  output logic [$clog2(X_MAX)-1:0]      sram_x_addr,
  output logic [$clog2(Y_MAX)-1:0]      sram_y_addr,
  output logic                          sram_ren,
  output logic                          sram_wen,
  input  logic [PIXEL_DEPTH-1:0]        sram_rdat
);

  localparam int XW = $clog2(X_MAX);
  localparam int YW = $clog2(Y_MAX);
  localparam int XC = XW + 2;
  localparam int YC = YW + 2;

  localparam logic signed [XC-1:0] XLIM = XC'(X_MAX);
  localparam logic signed [YC-1:0] YLIM = YC'(Y_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [4:0]           seq_idx;
  logic [XW-1:0]        cx_q;
  logic [YW-1:0]        cy_q;
  logic signed [2:0]    odx;
  logic signed [2:0]    ody;
  logic signed [XC-1:0] px;
  logic signed [YC-1:0] py;
  logic                 oob;

  logic                   pend_vld;
  logic                   pend_oob;
  logic [4:0]             pend_idx;
  logic [3:0]             ring_k;
  logic [PIXEL_DEPTH-1:0] cap;

  // Slot 0 is the centre; slot k+1 is ring point k.
  always_comb begin
    odx = 3'sd0;
    ody = 3'sd0;
    case (seq_idx)
      5'd1:  begin odx =  3'sd0; ody = -3'sd3; end
      5'd2:  begin odx =  3'sd1; ody = -3'sd3; end
      5'd3:  begin odx =  3'sd2; ody = -3'sd2; end
      5'd4:  begin odx =  3'sd3; ody = -3'sd1; end
      5'd5:  begin odx =  3'sd3; ody =  3'sd0; end
      5'd6:  begin odx =  3'sd3; ody =  3'sd1; end
      5'd7:  begin odx =  3'sd2; ody =  3'sd2; end
      5'd8:  begin odx =  3'sd1; ody =  3'sd3; end
      5'd9:  begin odx =  3'sd0; ody =  3'sd3; end
      5'd10: begin odx = -3'sd1; ody =  3'sd3; end
      5'd11: begin odx = -3'sd2; ody =  3'sd2; end
      5'd12: begin odx = -3'sd3; ody =  3'sd1; end
      5'd13: begin odx = -3'sd3; ody =  3'sd0; end
      5'd14: begin odx = -3'sd3; ody = -3'sd1; end
      5'd15: begin odx = -3'sd2; ody = -3'sd2; end
      5'd16: begin odx = -3'sd1; ody = -3'sd3; end
      default: begin odx = 3'sd0; ody = 3'sd0; end
    endcase
  end

  always_comb begin
    px  = $signed({2'b00, cx_q}) + XC'(odx);
    py  = $signed({2'b00, cy_q}) + YC'(ody);
    oob = (px < 0) || (px >= XLIM) ||
          (py < 0) || (py >= YLIM);
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign sram_wen = 1'b0;
  assign sram_ren = (state == ISSUE) && !oob;

  // Idle addresses are parked at zero so they never carry X.
  assign sram_x_addr = sram_ren ? px[XW-1:0] : '0;
  assign sram_y_addr = sram_ren ? py[YW-1:0] : '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = ISSUE;
      ISSUE: if (seq_idx == 5'd16) state_nx = DRAIN;
      DRAIN: state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      seq_idx <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        cx_q    <= cx;
        cy_q    <= cy;
        seq_idx <= '0;
      end else if (state == ISSUE) begin
        seq_idx <= seq_idx + 5'd1;
      end
    end
  end

  assign cap    = pend_oob ? '0 : sram_rdat;
  assign ring_k = pend_idx[3:0] - 4'd1;

  // The slot tag trails the issue by one cycle to meet the read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_oob  <= 1'b0;
      pend_idx  <= '0;
      center_px <= '0;
      ring_px   <= '0;
    end else begin
      pend_vld <= (state == ISSUE);
      pend_oob <= oob;
      pend_idx <= seq_idx;
      if (pend_vld) begin
        if (pend_idx == 5'd0)
          center_px <= cap;
        else
          ring_px[ring_k*PIXEL_DEPTH +: PIXEL_DEPTH] <= cap;
      end
    end
  end

endmodule

// File: tb/tb_fast_ring_fetcher.sv
// Scoreboard bench for fast_ring_fetcher on an 8x8 image with a
// behavioural SRAM and a point-list reference model.
module tb_fast_ring_fetcher;

  localparam int PD = 8;
  localparam int XM = 8;
  localparam int YM = 8;

  localparam int DXS[16] = '{0, 1, 2, 3, 3, 3, 2, 1,
                             0, -1, -2, -3, -3, -3, -2, -1};
  localparam int DYS[16] = '{-3, -3, -2, -1, 0, 1, 2, 3,
                             3, 3, 2, 1, 0, -1, -2, -3};

  typedef struct packed {
    logic [7:0]       c;
    logic [127:0]     r;
    logic [4:0]       nren;
    logic [16:0][5:0] a;
    logic [31:0]      done_cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2:0]     cx;
  logic [2:0]     cy;
  logic           busy;
  logic           done;
  logic [PD-1:0]  center_px;
  logic [16*PD-1:0] ring_px;
  logic [2:0]     sram_x_addr;
  logic [2:0]     sram_y_addr;
  logic           sram_ren;
  logic           sram_wen;
  logic [PD-1:0]  sram_rdat = '0;

  logic [7:0] mem [64];
  exp_t       exp_q [$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         m_rem = 0;
  int         dones = 0;

  fast_ring_fetcher #(
    .PIXEL_DEPTH(PD),
    .X_MAX(XM),
    .Y_MAX(YM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cx(cx),
    .cy(cy),
    .busy(busy),
    .done(done),
    .center_px(center_px),
    .ring_px(ring_px),
    .sram_x_addr(sram_x_addr),
    .sram_y_addr(sram_y_addr),
    .sram_ren(sram_ren),
    .sram_wen(sram_wen),
    .sram_rdat(sram_rdat)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (sram_ren) sram_rdat <= mem[{sram_y_addr, sram_x_addr}];

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic exp_t build(int x, int y);
    exp_t e;
    int px, py;
    logic [7:0] v;
    e = '0;
    for (int i = 0; i < 17; i++) begin
      px = x;
      py = y;
      if (i > 0) begin
        px = x + DXS[i-1];
        py = y + DYS[i-1];
      end
      if (px < 0 || px >= XM || py < 0 || py >= YM) begin
        v = 8'h00;
      end else begin
        v = mem[py*XM + px];
        e.a[e.nren] = {3'(py), 3'(px)};
        e.nren++;
      end
      if (i == 0) e.c = v;
      else e.r[(i-1)*8 +: 8] = v;
    end
    return e;
  endfunction

  function automatic logic [7:0] rk(int k);
    return ring_px[k*PD +: PD];
  endfunction

  // Reference model: acceptance only when its own 19-cycle window is over.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_rem = 0;
        exp_q.delete();
      end else if (m_rem > 0) begin
        m_rem--;
      end else if (start) begin
        e = build(int'(cx), int'(cy));
        e.done_cyc = 32'(cyc + 18);
        exp_q.push_back(e);
        m_rem = 19;
      end
    end
  end

  // Monitor
  initial begin
    int ren_n, busy_n;
    logic prev_done;
    exp_t e;
    ren_n = 0;
    busy_n = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_ren", 128'(sram_ren), 128'(0));
        chk("rst_center", 128'(center_px), 128'(0));
        chk("rst_ring", ring_px, 128'(0));
        ren_n = 0;
        busy_n = 0;
        prev_done = 1'b0;
      end else begin
        if (busy) busy_n++;
        if (sram_ren) begin
          if (exp_q.size() == 0) begin
            chk("ren_unexpected", 128'(sram_ren), 128'(0));
          end else if (ren_n >= int'(exp_q[0].nren)) begin
            chk("ren_extra", 128'(ren_n), 128'(exp_q[0].nren));
          end else begin
            chk("sram_addr", 128'({sram_y_addr, sram_x_addr}),
                128'(exp_q[0].a[ren_n]));
          end
          ren_n++;
        end
        if (done) begin
          dones++;
          chk("done_pulse", 128'(prev_done), 128'(0));
          if (exp_q.size() == 0) begin
            chk("done_unexpected", 128'(done), 128'(0));
          end else begin
            e = exp_q.pop_front();
            chk("center", 128'(center_px), 128'(e.c));
            chk("ring", ring_px, e.r);
            chk("ren_count", 128'(ren_n), 128'(e.nren));
            chk("busy_len", 128'(busy_n), 128'(19));
            chk("done_cycle", 128'(cyc), 128'(e.done_cyc));
            chk("wen", 128'(sram_wen), 128'(0));
          end
          ren_n = 0;
          busy_n = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_rem != 0 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("idle_timeout", 128'(m_rem), 128'(0));
  endtask

  task automatic fetch(int x, int y);
    wait_idle();
    cx = 3'(x);
    cy = 3'(y);
    start = 1'b1;
    tick();
    start = 1'b0;
    cx = 3'($urandom);
    cy = 3'($urandom);
  endtask

  task automatic check_44();
    chk("c44_center", 128'(center_px), 128'(8'h24));
    chk("c44_r0", 128'(rk(0)), 128'(8'h0C));
    chk("c44_r4", 128'(rk(4)), 128'(8'h27));
    chk("c44_r8", 128'(rk(8)), 128'(8'h3C));
    chk("c44_r12", 128'(rk(12)), 128'(8'h21));
    chk("c44_r2", 128'(rk(2)), 128'(8'h16));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    rst = 1'b1;
    start = 1'b0;
    cx = '0;
    cy = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    fetch(4, 4);
    wait_idle();
    check_44();

    fetch(0, 0);
    wait_idle();
    chk("c00_center", 128'(center_px), 128'(8'h00));
    chk("c00_r4", 128'(rk(4)), 128'(8'h03));
    chk("c00_r5", 128'(rk(5)), 128'(8'h0B));
    chk("c00_r8", 128'(rk(8)), 128'(8'h18));
    chk("c00_r12", 128'(rk(12)), 128'(8'h00));
    chk("c00_r0", 128'(rk(0)), 128'(8'h00));

    fetch(7, 7);
    wait_idle();
    chk("c77_r12", 128'(rk(12)), 128'(8'h3C));
    chk("c77_r0", 128'(rk(0)), 128'(8'h27));
    chk("c77_r4", 128'(rk(4)), 128'(8'h00));
    chk("c77_r8", 128'(rk(8)), 128'(8'h00));

    // Stray starts mid-fetch and in the done cycle.
    d0 = dones;
    fetch(3, 2);
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (m_rem != 1 && n < 40) begin
      tick();
      n++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (25) tick();
    chk("ignored_starts", 128'(dones - d0), 128'(1));

    // Held start: back-to-back fetches, centre inputs churn every cycle.
    d0 = dones;
    for (int i = 0; i < 61; i++) begin
      start = 1'b1;
      cx = 3'($urandom);
      cy = 3'($urandom);
      tick();
    end
    start = 1'b0;
    wait_idle();
    chk("held_dones", 128'(dones - d0), 128'(4));

    // Reset in the middle of a fetch.
    d0 = dones;
    fetch(4, 4);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 128'(busy), 128'(0));
    chk("post_rst_ring", ring_px, 128'(0));
    chk("post_rst_nodone", 128'(dones - d0), 128'(0));
    fetch(4, 4);
    wait_idle();
    check_44();

    // Random image, random centres, random stray starts.
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 30; t++) begin
      fetch(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      n = int'($urandom_range(0, 25));
      for (int j = 0; j < n; j++) begin
        start = ($urandom_range(0, 3) == 0);
        tick();
      end
      start = 1'b0;
    end
    wait_idle();
    repeat (3) tick();
    chk("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
